huffman_bit_packer: RTL and testbench
=====================================

# huffman_bit_packer

Downstream neighbour of the Huffman encoder: consumes its variable-length code words (Huffman code concatenated with appended magnitude bits) and packs them MSB-first into a byte stream. Inserts JPEG byte stuffing (0x00 after every 0xFF) and pads the final partial byte with 1s on flush. Output feeds the entropy-coded segment writer.

## Interface
- IN_W, 32, max code-word width in bits
- LEN_W, 6, width of length field (0..IN_W)
- ACC_W, 64, bit accumulator width (must be ≥ 2*IN_W)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  code word present
- in_ready  out  1  packer accepts a code word this cycle
- in_code  in  IN_W  code word, right-aligned; only low in_len bits are used
- in_len  in  LEN_W  number of valid bits, 0..IN_W; values > IN_W are illegal
- in_flush  in  1  qualifies in_valid: last word of segment, pad and drain afterwards
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer takes byte
- out_byte  out  8  packed byte
- out_last  out  1  final byte of segment
- busy  out  1  accumulator non-empty, stuff pending, or flush in progress

## Operation
- Accumulator acc[ACC_W] + count cnt (0..ACC_W). Accepted word appended below existing bits; emission takes the top 8 valid bits.
- in_ready = (state==RUN) && (cnt ≤ ACC_W−IN_W). Independent of in_valid.
- States: RUN (normal), STUFF (0x00 owed), FLUSH (draining after in_flush).
- Output register loads when (!out_valid || out_ready) and a byte is available; priority: STUFF byte, then accumulator byte if cnt≥8, then (FLUSH only) padded final byte when 0<cnt<8: remaining bits followed by 1s.
- Loading 0xFF from the accumulator sets STUFF; next load is 0x00 without consuming accumulator bits; returns to RUN or FLUSH.
- Accept of word with in_flush=1: state→FLUSH; in_ready low until drain complete.
- out_last=1 on the last byte loaded in FLUSH (cnt becomes 0 and no stuff owed); if that byte is 0xFF, out_last is carried by the following 0x00. After it is taken, state→RUN.
- Flush with cnt=0 after append (e.g. in_len=0, empty buffer): no byte emitted, no out_last, state→RUN next cycle.
- in_len=0 without flush: accepted, no effect.
- Arithmetic: cnt updates as cnt + (accept ? in_len : 0) − (load_from_acc ? min(cnt,8) : 0); never exceeds ACC_W given the in_ready rule.

## Timing
- Reset values: in_ready 1 (after reset state RUN, cnt 0), out_valid 0, out_byte 0x00, out_last 0, busy 0; state RUN, acc 0.
- Latency: word accepted at edge N that completes a byte → out_valid at N+1.
- Throughput: one accept and one byte load in the same cycle allowed; one byte per cycle sustained.
- out_byte/out_last stable while out_valid && !out_ready.
- rst_n low mid-stream: immediate clear of all state and pending bytes; nothing resumes.

## Configuration
- HUFF_BYTE_STUFF_EN defined: 0x00 inserted after every 0xFF (including padded final byte); STUFF state present.
- Not defined: no stuffing, STUFF state absent; 0xFF passes as ordinary data, out_last on last data byte.

## Structure
- huffman_pkg: IN_W/LEN_W/ACC_W defaults, state enum (RUN, STUFF, FLUSH), constants STUFF_TRIGGER=8'hFF, STUFF_BYTE=8'h00, PAD_BIT=1'b1.
- One sub-module: huff_bit_acc (accumulator, cnt, append/extract, pad generation); top holds FSM and output register.

## Test plan
- code 0xA5 len 8 + flush → single byte 0xA5, out_last=1, busy 0 afterwards.
- code 0b101 len 3 + flush → 0xBF (101 + 11111), out_last=1.
- 0xFF len 8, then 0x12 len 8 + flush → 0xFF, 0x00, 0x12 (last); without HUFF_BYTE_STUFF_EN → 0xFF, 0x12 (last).
- code 0x7F len 7 + flush → pad makes 0xFF, then 0x00 with out_last=1.
- out_ready held low 20 cycles, stream 0x89ABCDEF len 32 ×4 → in_ready drops once cnt>32; after release bytes 89 AB CD EF repeated in order, none lost, output stable while stalled.
- rst_n asserted with cnt=20 and out_valid=1 → out_valid 0, busy 0 immediately; next word 0x3C len 8 + flush → 0x3C only.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared widths, FSM state type and byte constants for the Huffman bit packer.
// Optional feature macro: HUFF_BYTE_STUFF_EN (adds the STUFF state).
package huffman_pkg;

    localparam int IN_W  = 32;                  // max code-word width in bits
    localparam int LEN_W = 6;                   // width of the length field
    localparam int ACC_W = 64;                  // bit accumulator width, >= 2*IN_W
    localparam int CNT_W = $clog2(ACC_W + 1);   // holds 0..ACC_W

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1
`ifdef HUFF_BYTE_STUFF_EN
        ,
        STUFF = 2'd2
`endif
    } state_t;

    localparam logic [7:0] STUFF_TRIGGER = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;
    localparam logic       PAD_BIT       = 1'b1;

endpackage

// File: rtl/huffman_bit_packer_if.sv
// Code-word input stream and byte output stream of the Huffman bit packer.
// Handshake: a transfer happens on a rising clock edge where valid && ready;
// ready never depends on valid, and the sender keeps payload stable while
// valid is high and ready is low.
interface huffman_bit_packer_if;
    import huffman_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic [LEN_W-1:0] in_len;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_last;

    // Packer side
    modport slave (
        input  in_valid, in_code, in_len, in_flush, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_code, in_len, in_flush, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/huff_bit_acc.sv
// MSB-first bit accumulator: appends right-aligned code words below the
// existing bits and hands out the top byte (plain or 1-padded).
// Invariant: every bit below the cnt valid bits is zero.
module huff_bit_acc
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             append,
    input  logic [IN_W-1:0]  code,
    input  logic [LEN_W-1:0] len,
    input  logic             take,
    output logic [CNT_W-1:0] cnt,
    output logic [7:0]       top_byte,
    output logic [7:0]       pad_byte
);

    logic [ACC_W-1:0] acc, acc_mid, word_top, acc_next;
    logic [CNT_W-1:0] cnt_mid, cnt_next, take_n;
    logic [LEN_W-1:0] drop_n;

    // Extract up to 8 bits first, then place the new word right under what is left
    always_comb begin
        take_n   = '0;
        word_top = '0;
        if (take) take_n = (cnt >= CNT_W'(8)) ? CNT_W'(8) : cnt;
        acc_mid  = take ? (acc << 8) : acc;
        cnt_mid  = cnt - take_n;
        // Shifting left by IN_W-len discards the unused high bits of the code
        drop_n   = LEN_W'(IN_W) - len;
        acc_next = acc_mid;
        cnt_next = cnt_mid;
        if (append) begin
            word_top = ({code, {(ACC_W-IN_W){1'b0}}} << drop_n) >> cnt_mid;
            acc_next = acc_mid | word_top;
            cnt_next = cnt_mid + CNT_W'(len);
        end
    end

    // Accumulator and bit count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
        end
    end

    assign top_byte = acc[ACC_W-1 -: 8];
    // Only meaningful when cnt < 8: fill the bits after the valid ones with PAD_BIT
    assign pad_byte = top_byte | ({8{PAD_BIT}} >> cnt[2:0]);

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman code words into an MSB-first byte stream,
// pads the final partial byte with 1s on flush and, when HUFF_BYTE_STUFF_EN
// is defined, inserts 0x00 after every 0xFF byte.
module huffman_bit_packer
    import huffman_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    huffman_bit_packer_if.slave         bus,
    output logic                        busy,
    output state_t                      dbg_state
);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       top_byte, pad_byte;
    logic             can_load, in_ready, accept, take, load, load_last;
    logic [7:0]       load_byte;
    logic             out_valid_q, out_last_q;
    logic [7:0]       out_byte_q;
`ifdef HUFF_BYTE_STUFF_EN
    logic             ret_flush, ret_d;     // state to resume after the 0x00
    logic             stuff_last, slast_d;  // owed 0x00 closes the segment
`endif

    huff_bit_acc u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .append   (accept),
        .code     (bus.in_code),
        .len      (bus.in_len),
        .take     (take),
        .cnt      (cnt),
        .top_byte (top_byte),
        .pad_byte (pad_byte)
    );

    assign can_load = !out_valid_q || bus.out_ready;
    assign in_ready = (state == RUN) && (cnt <= CNT_W'(ACC_W - IN_W));
    assign accept   = bus.in_valid && in_ready;

    // Next state and byte selection: owed stuff byte, full byte, then padded tail
    always_comb begin
        state_d   = state;
        take      = 1'b0;
        load      = 1'b0;
        load_byte = '0;
        load_last = 1'b0;
`ifdef HUFF_BYTE_STUFF_EN
        ret_d     = ret_flush;
        slast_d   = stuff_last;
        if (state == STUFF) begin
            if (can_load) begin
                load      = 1'b1;
                load_byte = STUFF_BYTE;
                load_last = stuff_last;
                state_d   = ret_flush ? FLUSH : RUN;
            end
        end else
`endif
        begin
            if (can_load && cnt >= CNT_W'(8)) begin
                load      = 1'b1;
                take      = 1'b1;
                load_byte = top_byte;
                load_last = (state == FLUSH) && (cnt == CNT_W'(8));
            end else if (can_load && state == FLUSH && cnt != '0) begin
                load      = 1'b1;
                take      = 1'b1;
                load_byte = pad_byte;
                load_last = 1'b1;
            end
            if (accept && bus.in_flush)
                state_d = FLUSH;
            else if (state == FLUSH && cnt == '0 && can_load)
                state_d = RUN;
`ifdef HUFF_BYTE_STUFF_EN
            if (load && load_byte == STUFF_TRIGGER) begin
                state_d   = STUFF;
                ret_d     = (state == FLUSH) || (accept && bus.in_flush);
                slast_d   = load_last;
                load_last = 1'b0;
            end
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
`ifdef HUFF_BYTE_STUFF_EN
            ret_flush  <= 1'b0;
            stuff_last <= 1'b0;
`endif
        end else begin
            state <= state_d;
`ifdef HUFF_BYTE_STUFF_EN
            ret_flush  <= ret_d;
            stuff_last <= slast_d;
`endif
        end
    end

    // Output byte register: holds while stalled, drops valid once taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_byte_q  <= load_byte;
            out_last_q  <= load_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (cnt != '0) || (state != RUN);
    assign dbg_state     = state;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: table of short segments with
// hand-computed byte streams, plus stall and mid-stream reset sequences.
// Expectations follow HUFF_BYTE_STUFF_EN when it is defined.
module tb_huffman_bit_packer;
    import huffman_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic   clk = 1'b0;
    logic   rst_n;
    logic   busy;
    state_t dbg_state;

    always #5 clk = ~clk;

    huffman_bit_packer_if bus();

    huffman_bit_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];     // {last, byte}
    logic [8:0] mon_e;
    logic       sent_done;
    logic       saw_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every byte the consumer takes must be the next expected one
    always begin
        @(negedge clk);
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %02h last %0b, required no byte (t=%0t)",
                         bus.out_byte, bus.out_last, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_byte", {24'h0, bus.out_byte}, {24'h0, mon_e[7:0]});
                check("out_last", {31'h0, bus.out_last}, {31'h0, mon_e[8]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the accept
    task automatic send_word(input logic [31:0] code, input logic [5:0] len, input logic fl);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        bus.in_len   = len;
        bus.in_flush = fl;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, required 1", n);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || bus.out_valid || !sent_done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_busy"}, {31'h0, busy}, 0);
        check({name, "_in_ready"}, {31'h0, bus.in_ready}, 1);
        check({name, "_out_valid"}, {31'h0, bus.out_valid}, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        int               nw;
        logic [1:0][31:0] code;
        logic [1:0][5:0]  len;
        logic [1:0]       fl;
        int               nb;
        logic [2:0][8:0]  exp;
    } vec_t;

    function automatic vec_t mk(int nw, logic [31:0] c0, logic [5:0] l0, logic f0,
                                logic [31:0] c1, logic [5:0] l1, logic f1,
                                int nb, logic [8:0] e0, logic [8:0] e1, logic [8:0] e2);
        vec_t v;
        v.nw = nw;
        v.code[0] = c0; v.len[0] = l0; v.fl[0] = f0;
        v.code[1] = c1; v.len[1] = l1; v.fl[1] = f1;
        v.nb = nb;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        return v;
    endfunction

    localparam int NV = 7;
    vec_t vecs[NV];

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = mk(1, 32'hA5, 6'd8, 1'b1, 32'h0, 6'd0, 1'b0, 1, 9'h1A5, 9'h0, 9'h0);
        vecs[1] = mk(1, 32'h5, 6'd3, 1'b1, 32'h0, 6'd0, 1'b0, 1, 9'h1BF, 9'h0, 9'h0);
        vecs[2] = mk(1, 32'hABC, 6'd12, 1'b1, 32'h0, 6'd0, 1'b0, 2, 9'h0AB, 9'h1CF, 9'h0);
        vecs[3] = mk(1, 32'h0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 0, 9'h0, 9'h0, 9'h0);
`ifdef HUFF_BYTE_STUFF_EN
        vecs[4] = mk(2, 32'hFF, 6'd8, 1'b0, 32'h12, 6'd8, 1'b1, 3, 9'h0FF, 9'h000, 9'h112);
        vecs[5] = mk(1, 32'h7F, 6'd7, 1'b1, 32'h0, 6'd0, 1'b0, 2, 9'h0FF, 9'h100, 9'h0);
        vecs[6] = mk(2, 32'h3, 6'd2, 1'b0, 32'h3F, 6'd6, 1'b1, 2, 9'h0FF, 9'h100, 9'h0);
`else
        vecs[4] = mk(2, 32'hFF, 6'd8, 1'b0, 32'h12, 6'd8, 1'b1, 2, 9'h0FF, 9'h112, 9'h0);
        vecs[5] = mk(1, 32'h7F, 6'd7, 1'b1, 32'h0, 6'd0, 1'b0, 1, 9'h1FF, 9'h0, 9'h0);
        vecs[6] = mk(2, 32'h3, 6'd2, 1'b0, 32'h3F, 6'd6, 1'b1, 1, 9'h1FF, 9'h0, 9'h0);
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_len    = '0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b1;
        sent_done     = 1'b1;
        saw_low       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", {31'h0, bus.in_ready}, 1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 0);
        check("rst_out_byte", {24'h0, bus.out_byte}, 0);
        check("rst_out_last", {31'h0, bus.out_last}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_state", {30'h0, dbg_state}, {30'h0, RUN});

        // Table-driven segments
        for (int i = 0; i < NV; i++) begin
            for (int b = 0; b < vecs[i].nb; b++) exp_q.push_back(vecs[i].exp[b]);
            for (int w = 0; w < vecs[i].nw; w++)
                send_word(vecs[i].code[w], vecs[i].len[w], vecs[i].fl[w]);
            wait_idle($sformatf("vec%0d", i));
        end

        // Consumer stalled 20 cycles while four 32-bit words arrive
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(9'h089);
            exp_q.push_back(9'h0AB);
            exp_q.push_back(9'h0CD);
            exp_q.push_back(9'h0EF);
        end
        sent_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send_word(32'h89ABCDEF, 6'd32, 1'b0);
                sent_done = 1'b1;
            end
        join_none
        repeat (20) begin
            @(negedge clk);
            if (!bus.in_ready) saw_low = 1'b1;
            if (bus.out_valid) check("stall_stable", {24'h0, bus.out_byte}, 32'h89);
        end
        check("stall_in_ready_dropped", {31'h0, saw_low}, 1);
        check("stall_in_ready_low", {31'h0, bus.in_ready}, 0);
        check("stall_out_valid", {31'h0, bus.out_valid}, 1);
        bus.out_ready = 1'b1;
        wait_idle("stall");

        // Reset with 20 bits buffered and a byte waiting at the output
        bus.out_ready = 1'b0;
        send_word(32'h0ABCDEF1, 6'd28, 1'b0);
        @(negedge clk);
        check("pre_rst_out_valid", {31'h0, bus.out_valid}, 1);
        check("pre_rst_out_byte", {24'h0, bus.out_byte}, 32'hAB);
        check("pre_rst_busy", {31'h0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'h0, bus.out_valid}, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_in_ready", {31'h0, bus.in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(9'h13C);
        send_word(32'h3C, 6'd8, 1'b1);
        wait_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if something wedges
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
